// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the fetch/MEM-stage memory port arbiter.
// The MEM_ARB_RR_EN build option itself lives in mem_bus_arbiter.sv.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIAddr,
        StIWait,
        StDAddr,
        StDWait
    } arbState_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    // Fixed priority is the round-robin rule called with lastGnt tied to GNT_INST.
    function automatic logic pickGrant(input logic instReq, input logic dataReq,
                                       input logic lastGnt);
        logic gnt;
        gnt = GNT_INST;
        if (dataReq && (!instReq || lastGnt == GNT_INST)) begin
            gnt = GNT_DATA;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Core-side request/response signals and the shared SRAM-like memory port.
// master: the arbiter's view. slave: the core plus memory that surround it.
interface mem_bus_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();

    // Fetch side
    logic            inst_req;
    logic [AW-1:0]   inst_addr;
    logic [DW-1:0]   inst_rdata;
    logic            inst_data_ok;
    logic            inst_stall;

    // MEM-stage side
    logic            data_req;
    logic            data_wr;
    logic [1:0]      data_size;
    logic [DW/8-1:0] data_wen;
    logic [AW-1:0]   data_addr;
    logic [DW-1:0]   data_wdata;
    logic [DW-1:0]   data_rdata;
    logic            data_data_ok;
    logic            data_stall;

    // Memory port
    logic            mem_req;
    logic            mem_wr;
    logic [1:0]      mem_size;
    logic [DW/8-1:0] mem_wen;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_addr_ok;
    logic            mem_data_ok;
    logic [DW-1:0]   mem_rdata;

    modport master (
        input  inst_req, inst_addr,
        output inst_rdata, inst_data_ok, inst_stall,
        input  data_req, data_wr, data_size, data_wen, data_addr, data_wdata,
        output data_rdata, data_data_ok, data_stall,
        output mem_req, mem_wr, mem_size, mem_wen, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_rdata, inst_data_ok, inst_stall,
        output data_req, data_wr, data_size, data_wen, data_addr, data_wdata,
        input  data_rdata, data_data_ok, data_stall,
        input  mem_req, mem_wr, mem_size, mem_wen, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch and MEM stage, one transaction in flight.
// Define MEM_ARB_RR_EN to alternate grants on ties; otherwise data always wins a tie.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.master bus
);

    arbState_e       state;
    logic            grant;
    logic            nextGrant;
    logic            anyReq;
    logic            inWait;

    logic            memReq;
    logic            memWr;
    logic [1:0]      memSize;
    logic [DW/8-1:0] memWen;
    logic [AW-1:0]   memAddr;
    logic [DW-1:0]   memWdata;

    logic            instOk;
    logic            dataOk;

    assign anyReq = bus.inst_req | bus.data_req;

`ifdef MEM_ARB_RR_EN
    logic lastGrant;

    assign nextGrant = pickGrant(bus.inst_req, bus.data_req, lastGrant);

    // Reset to inst so the first tie still goes to the data side.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant <= GNT_INST;
        end else if (state == StIdle && anyReq) begin
            lastGrant <= nextGrant;
        end
    end
`else
    assign nextGrant = pickGrant(bus.inst_req, bus.data_req, GNT_INST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            grant    <= GNT_INST;
            memReq   <= 1'b0;
            memWr    <= 1'b0;
            memSize  <= SZ_BYTE;
            memWen   <= '0;
            memAddr  <= '0;
            memWdata <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (anyReq) begin
                        grant  <= nextGrant;
                        memReq <= 1'b1;
                        if (nextGrant == GNT_DATA) begin
                            state    <= StDAddr;
                            memWr    <= bus.data_wr;
                            memSize  <= bus.data_size;
                            // Loads never carry byte enables onto the bus.
                            memWen   <= bus.data_wr ? bus.data_wen : '0;
                            memAddr  <= bus.data_addr;
                            memWdata <= bus.data_wdata;
                        end else begin
                            state    <= StIAddr;
                            memWr    <= 1'b0;
                            memSize  <= SZ_WORD;
                            memWen   <= '0;
                            memAddr  <= bus.inst_addr;
                            memWdata <= '0;
                        end
                    end
                end
                StIAddr, StDAddr: begin
                    // A data_ok alongside addr_ok belongs to nobody here and is dropped.
                    if (bus.mem_addr_ok) begin
                        state  <= (state == StIAddr) ? StIWait : StDWait;
                        memReq <= 1'b0;
                        memWr  <= 1'b0;
                        memWen <= '0;
                    end
                end
                StIWait, StDWait: begin
                    if (bus.mem_data_ok) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state  <= StIdle;
                    memReq <= 1'b0;
                end
            endcase
        end
    end

    assign inWait = (state == StIWait) || (state == StDWait);

    always_comb begin
        instOk = 1'b0;
        dataOk = 1'b0;
        if (!rst && inWait && bus.mem_data_ok) begin
            if (grant == GNT_DATA) begin
                dataOk = 1'b1;
            end else begin
                instOk = 1'b1;
            end
        end
    end

    assign bus.mem_req      = memReq;
    assign bus.mem_wr       = memWr;
    assign bus.mem_size     = memSize;
    assign bus.mem_wen      = memWen;
    assign bus.mem_addr     = memAddr;
    assign bus.mem_wdata    = memWdata;

    assign bus.inst_data_ok = instOk;
    assign bus.data_data_ok = dataOk;
    assign bus.inst_rdata   = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;

    assign bus.inst_stall   = ~rst & bus.inst_req & ~instOk;
    assign bus.data_stall   = ~rst & bus.data_req & ~dataOk;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; tie-break expectations follow MEM_ARB_RR_EN.
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst;
    int   nChecks;
    int   nFails;

    mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge; outputs then reflect new state.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.inst_req    = 1'b0;
        bus.inst_addr   = '0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_size   = 2'd0;
        bus.data_wen    = '0;
        bus.data_addr   = '0;
        bus.data_wdata  = '0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1'b1;
        bus.inst_req = 1'b1;
        bus.data_req = 1'b1;
        cyc();
        cyc();
        #2;
        nChecks++; if (bus.mem_req !== 1'b0) begin nFails++; $display("FAIL rst_mem_req got %b want 0", bus.mem_req); end
        nChecks++; if (bus.mem_wr !== 1'b0) begin nFails++; $display("FAIL rst_mem_wr got %b want 0", bus.mem_wr); end
        nChecks++; if (bus.mem_wen !== 4'b0) begin nFails++; $display("FAIL rst_mem_wen got %b want 0", bus.mem_wen); end
        nChecks++; if (bus.mem_addr !== 32'h0) begin nFails++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
        nChecks++; if (bus.mem_wdata !== 32'h0) begin nFails++; $display("FAIL rst_mem_wdata got %h want 0", bus.mem_wdata); end
        nChecks++; if (bus.mem_size !== 2'd0) begin nFails++; $display("FAIL rst_mem_size got %0d want 0", bus.mem_size); end
        nChecks++; if (bus.inst_stall !== 1'b0) begin nFails++; $display("FAIL rst_inst_stall got %b want 0", bus.inst_stall); end
        nChecks++; if (bus.data_stall !== 1'b0) begin nFails++; $display("FAIL rst_data_stall got %b want 0", bus.data_stall); end
        cyc();
        rst = 1'b0;
        idleInputs();
        // A stray response in idle must not pulse either data_ok.
        bus.mem_data_ok = 1'b1;
        #2;
        nChecks++; if (bus.inst_data_ok !== 1'b0 || bus.data_data_ok !== 1'b0) begin nFails++; $display("FAIL idle_stray_ok got %b%b want 00", bus.inst_data_ok, bus.data_data_ok); end
        cyc();
        bus.mem_data_ok = 1'b0;
    endtask

    task automatic test_fetch();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC0_0000;
        #2;
        nChecks++; if (bus.inst_stall !== 1'b1) begin nFails++; $display("FAIL f_stall_n got %b want 1", bus.inst_stall); end
        nChecks++; if (bus.mem_req !== 1'b0) begin nFails++; $display("FAIL f_req_n got %b want 0", bus.mem_req); end
        cyc();
        bus.mem_addr_ok = 1'b1;
        #2;
        nChecks++; if (bus.mem_req !== 1'b1) begin nFails++; $display("FAIL f_req_n1 got %b want 1", bus.mem_req); end
        nChecks++; if (bus.mem_addr !== 32'hBFC0_0000) begin nFails++; $display("FAIL f_addr got %h want bfc00000", bus.mem_addr); end
        nChecks++; if (bus.mem_size !== 2'd2 || bus.mem_wr !== 1'b0 || bus.mem_wen !== 4'b0) begin nFails++; $display("FAIL f_attr got size=%0d wr=%b wen=%b want 2 0 0000", bus.mem_size, bus.mem_wr, bus.mem_wen); end
        nChecks++; if (bus.inst_stall !== 1'b1 || bus.inst_data_ok !== 1'b0) begin nFails++; $display("FAIL f_stall_n1 got stall=%b ok=%b want 1 0", bus.inst_stall, bus.inst_data_ok); end
        cyc();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h2408_0001;
        #2;
        nChecks++; if (bus.mem_req !== 1'b0) begin nFails++; $display("FAIL f_req_n2 got %b want 0", bus.mem_req); end
        nChecks++; if (bus.inst_data_ok !== 1'b1 || bus.data_data_ok !== 1'b0) begin nFails++; $display("FAIL f_ok got inst=%b data=%b want 1 0", bus.inst_data_ok, bus.data_data_ok); end
        nChecks++; if (bus.inst_rdata !== 32'h2408_0001) begin nFails++; $display("FAIL f_rdata got %h want 24080001", bus.inst_rdata); end
        nChecks++; if (bus.inst_stall !== 1'b0) begin nFails++; $display("FAIL f_stall_n2 got %b want 0", bus.inst_stall); end
        cyc();
        idleInputs();
        #2;
        nChecks++; if (bus.inst_data_ok !== 1'b0) begin nFails++; $display("FAIL f_ok_n3 got %b want 0", bus.inst_data_ok); end
        cyc();
        #2;
        nChecks++; if (bus.mem_req !== 1'b0) begin nFails++; $display("FAIL f_noreissue got %b want 0", bus.mem_req); end
    endtask

    task automatic test_store();
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_size  = 2'd0;
        bus.data_wen   = 4'b0100;
        bus.data_addr  = 32'h8000_0002;
        bus.data_wdata = 32'h00AB_0000;
        cyc();
        // addr_ok and data_ok together in the address phase: data_ok must be ignored.
        bus.mem_addr_ok = 1'b1;
        bus.mem_data_ok = 1'b1;
        #2;
        nChecks++; if (bus.mem_req !== 1'b1 || bus.mem_wr !== 1'b1) begin nFails++; $display("FAIL s_req got req=%b wr=%b want 1 1", bus.mem_req, bus.mem_wr); end
        nChecks++; if (bus.mem_wen !== 4'b0100 || bus.mem_size !== 2'd0) begin nFails++; $display("FAIL s_attr got wen=%b size=%0d want 0100 0", bus.mem_wen, bus.mem_size); end
        nChecks++; if (bus.mem_addr !== 32'h8000_0002 || bus.mem_wdata !== 32'h00AB_0000) begin nFails++; $display("FAIL s_addrdata got %h %h want 80000002 00ab0000", bus.mem_addr, bus.mem_wdata); end
        nChecks++; if (bus.data_data_ok !== 1'b0 || bus.data_stall !== 1'b1) begin nFails++; $display("FAIL s_early_ok got ok=%b stall=%b want 0 1", bus.data_data_ok, bus.data_stall); end
        cyc();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        #2;
        nChecks++; if (bus.mem_req !== 1'b0 || bus.data_data_ok !== 1'b0) begin nFails++; $display("FAIL s_wait got req=%b ok=%b want 0 0", bus.mem_req, bus.data_data_ok); end
        cyc();
        bus.mem_data_ok = 1'b1;
        #2;
        nChecks++; if (bus.data_data_ok !== 1'b1 || bus.inst_data_ok !== 1'b0) begin nFails++; $display("FAIL s_ok got data=%b inst=%b want 1 0", bus.data_data_ok, bus.inst_data_ok); end
        nChecks++; if (bus.data_stall !== 1'b0) begin nFails++; $display("FAIL s_stall got %b want 0", bus.data_stall); end
        cyc();
        idleInputs();
        cyc();
    endtask

    task automatic test_reset_in_wait();
        bus.data_req  = 1'b1;
        bus.data_size = 2'd2;
        bus.data_wen  = 4'b1111;
        bus.data_addr = 32'h8000_1000;
        cyc();
        bus.mem_addr_ok = 1'b1;
        cyc();
        bus.mem_addr_ok = 1'b0;
        rst = 1'b1;
        #2;
        nChecks++; if (bus.data_stall !== 1'b0) begin nFails++; $display("FAIL rw_stall got %b want 0", bus.data_stall); end
        cyc();
        rst = 1'b0;
        bus.data_req    = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'hDEAD_BEEF;
        #2;
        nChecks++; if (bus.data_data_ok !== 1'b0 || bus.inst_data_ok !== 1'b0) begin nFails++; $display("FAIL rw_ok got data=%b inst=%b want 0 0", bus.data_data_ok, bus.inst_data_ok); end
        nChecks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin nFails++; $display("FAIL rw_bus got req=%b addr=%h want 0 0", bus.mem_req, bus.mem_addr); end
        nChecks++; if (dut.state !== StIdle) begin nFails++; $display("FAIL rw_state got %0d want %0d", dut.state, StIdle); end
        cyc();
        idleInputs();
        cyc();
    endtask

    task automatic test_tie();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_0100;
        bus.data_req  = 1'b1;
        bus.data_wr   = 1'b0;
        bus.data_size = 2'd2;
        bus.data_wen  = 4'b1111;
        bus.data_addr = 32'h0000_2000;
        cyc();
        bus.mem_addr_ok = 1'b1;
        #2;
        nChecks++; if (bus.mem_addr !== 32'h0000_2000) begin nFails++; $display("FAIL t_first got %h want 00002000", bus.mem_addr); end
        nChecks++; if (bus.mem_wen !== 4'b0 || bus.mem_wr !== 1'b0) begin nFails++; $display("FAIL t_load got wen=%b wr=%b want 0000 0", bus.mem_wen, bus.mem_wr); end
        nChecks++; if (bus.inst_stall !== 1'b1) begin nFails++; $display("FAIL t_istall1 got %b want 1", bus.inst_stall); end
        cyc();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h1234_5678;
        #2;
        nChecks++; if (bus.data_data_ok !== 1'b1 || bus.inst_data_ok !== 1'b0) begin nFails++; $display("FAIL t_dok got data=%b inst=%b want 1 0", bus.data_data_ok, bus.inst_data_ok); end
        nChecks++; if (bus.data_rdata !== 32'h1234_5678 || bus.inst_stall !== 1'b1) begin nFails++; $display("FAIL t_drdata got %h stall=%b want 12345678 1", bus.data_rdata, bus.inst_stall); end
        cyc();
        bus.data_req    = 1'b0;
        bus.mem_data_ok = 1'b0;
        #2;
        nChecks++; if (bus.mem_req !== 1'b0 || bus.inst_stall !== 1'b1) begin nFails++; $display("FAIL t_gap got req=%b stall=%b want 0 1", bus.mem_req, bus.inst_stall); end
        cyc();
        bus.mem_addr_ok = 1'b1;
        #2;
        nChecks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0100 || bus.mem_size !== 2'd2) begin nFails++; $display("FAIL t_second got req=%b addr=%h size=%0d want 1 00000100 2", bus.mem_req, bus.mem_addr, bus.mem_size); end
        cyc();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        #2;
        nChecks++; if (bus.inst_data_ok !== 1'b1 || bus.data_data_ok !== 1'b0) begin nFails++; $display("FAIL t_iok got inst=%b data=%b want 1 0", bus.inst_data_ok, bus.data_data_ok); end
        cyc();
        idleInputs();
        cyc();
    endtask

    task automatic test_slow_addr();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC0_0040;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #2;
            nChecks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'hBFC0_0040) begin nFails++; $display("FAIL sa_hold%0d got req=%b addr=%h want 1 bfc00040", i, bus.mem_req, bus.mem_addr); end
        end
        bus.mem_addr_ok = 1'b1;
        cyc();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        #2;
        nChecks++; if (bus.inst_data_ok !== 1'b1 || bus.mem_req !== 1'b0) begin nFails++; $display("FAIL sa_ok got ok=%b req=%b want 1 0", bus.inst_data_ok, bus.mem_req); end
        cyc();
        idleInputs();
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [31:0] expSecond;
`ifdef MEM_ARB_RR_EN
        expSecond = 32'h0000_0300;
`else
        expSecond = 32'h0000_0500;
`endif
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_0300;
        bus.data_req  = 1'b1;
        bus.data_size = 2'd2;
        bus.data_addr = 32'h0000_0400;
        cyc();
        bus.mem_addr_ok = 1'b1;
        #2;
        nChecks++; if (bus.mem_addr !== 32'h0000_0400) begin nFails++; $display("FAIL bb_tie1 got %h want 00000400", bus.mem_addr); end
        cyc();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        cyc();
        // Next load arrives the cycle the arbiter returns to idle: a second tie.
        bus.mem_data_ok = 1'b0;
        bus.data_addr   = 32'h0000_0500;
        cyc();
        bus.mem_addr_ok = 1'b1;
        #2;
        nChecks++; if (bus.mem_addr !== expSecond) begin nFails++; $display("FAIL bb_tie2 got %h want %h", bus.mem_addr, expSecond); end
        cyc();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        #2;
        nChecks++; if ((bus.inst_data_ok !== (expSecond == 32'h0000_0300)) || (bus.data_data_ok !== (expSecond == 32'h0000_0500))) begin nFails++; $display("FAIL bb_ok2 got inst=%b data=%b for addr %h", bus.inst_data_ok, bus.data_data_ok, expSecond); end
        cyc();
        idleInputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        rst     = 1'b1;
        idleInputs();
        test_reset();
        test_fetch();
        test_store();
        test_reset_in_wait();
        test_tie();
        test_slow_addr();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
